// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: access FSM states and the default SRAM wait count.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int WAIT_STATES_DEF = 2;

endpackage

// File: rtl/mem_stage.sv
// MEM pipeline stage: one 16-bit load/store per instruction on async SRAM via a multi-cycle
// access FSM, stalling upstream for the access and inserting bubbles into mem_wb.
`default_nettype none

module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int WAIT_STATES = WAIT_STATES_DEF,
   parameter int ADDR_W      = 18
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              memread_i,
   input  logic              memwrite_i,
   input  logic [15:0]       addr_i,
   input  logic [15:0]       wdata_i,
   input  logic              memtoreg_i,
   input  logic [3:0]        regdst_i,
   input  logic              regwrite_i,
   input  logic [15:0]       alures_i,
   input  logic [15:0]       ram_rdata_i,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [15:0]       ram_wdata_o,
   output logic              ram_ce_n_o,
   output logic              ram_oe_n_o,
   output logic              ram_we_n_o,
   output logic              stall_o,
   output logic              memtoreg_o,
   output logic [3:0]        regdst_o,
   output logic              regwrite_o,
   output logic [15:0]       alures_o,
   output logic [15:0]       memres_o
);

   localparam int CNT_W = $clog2(WAIT_STATES + 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [15:0]      addr_q, addr_nx;
   logic [15:0]      wdata_q, wdata_nx;
   logic [15:0]      rdata_q, rdata_nx;
   logic             is_wr, is_wr_nx;
   logic             ce_n, ce_n_nx;
   logic             oe_n, oe_n_nx;
   logic             we_n, we_n_nx;
   logic             op;

   assign op = memread_i | memwrite_i;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         is_wr   <= 1'b0;
         ce_n    <= 1'b1;
         oe_n    <= 1'b1;
         we_n    <= 1'b1;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         addr_q  <= addr_nx;
         wdata_q <= wdata_nx;
         rdata_q <= rdata_nx;
         is_wr   <= is_wr_nx;
         ce_n    <= ce_n_nx;
         oe_n    <= oe_n_nx;
         we_n    <= we_n_nx;
      end
   end

   // Strobes are computed one cycle ahead so the SRAM pins come straight from flops.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      addr_nx  = addr_q;
      wdata_nx = wdata_q;
      rdata_nx = rdata_q;
      is_wr_nx = is_wr;
      ce_n_nx  = ce_n;
      oe_n_nx  = oe_n;
      we_n_nx  = we_n;
      case (state)
         IDLE: begin
            if (op) begin
               addr_nx  = addr_i;
               wdata_nx = wdata_i;
               is_wr_nx = memwrite_i;
               cnt_nx   = CNT_W'(WAIT_STATES);
               ce_n_nx  = 1'b0;
               oe_n_nx  = memwrite_i;
               we_n_nx  = ~memwrite_i;
               state_nx = ACCESS;
            end
         end
         ACCESS: begin
            cnt_nx = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               if (!is_wr) begin
                  rdata_nx = ram_rdata_i;
               end
               ce_n_nx  = 1'b1;
               oe_n_nx  = 1'b1;
               we_n_nx  = 1'b1;
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign stall_o     = ~RST & (((state == IDLE) & op) | (state == ACCESS));
   assign ram_addr_o  = {{(ADDR_W-16){1'b0}}, addr_q};
   assign ram_wdata_o = wdata_q;
   assign ram_ce_n_o  = ce_n;
   assign ram_oe_n_o  = oe_n;
   assign ram_we_n_o  = we_n;
   assign memtoreg_o  = memtoreg_i;
   assign regdst_o    = regdst_i;
   assign regwrite_o  = regwrite_i & ~stall_o;
   assign alures_o    = alures_i;
   assign memres_o    = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage with a small behavioural SRAM model.
`default_nettype none

module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        memread, memwrite, memtoreg, regwrite;
   logic [15:0] addr, wdata, alures, ram_rdata;
   logic [3:0]  regdst;
   logic [17:0] ram_addr;
   logic [15:0] ram_wdata, alures_o, memres;
   logic        ce_n, oe_n, we_n, stall, memtoreg_o, regwrite_o;
   logic [3:0]  regdst_o;

   int checks = 0;
   int errors = 0;

   logic [15:0] sram [0:1023];

   always #5 clk = ~clk;

   mem_stage #(.WAIT_STATES(2), .ADDR_W(18)) dut (
      .CLK(clk), .RST(rst),
      .memread_i(memread), .memwrite_i(memwrite), .addr_i(addr), .wdata_i(wdata),
      .memtoreg_i(memtoreg), .regdst_i(regdst), .regwrite_i(regwrite), .alures_i(alures),
      .ram_rdata_i(ram_rdata),
      .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
      .ram_ce_n_o(ce_n), .ram_oe_n_o(oe_n), .ram_we_n_o(we_n),
      .stall_o(stall), .memtoreg_o(memtoreg_o), .regdst_o(regdst_o),
      .regwrite_o(regwrite_o), .alures_o(alures_o), .memres_o(memres)
   );

   // Async SRAM: read data visible only while selected and output-enabled
   assign ram_rdata = (!ce_n && !oe_n) ? sram[ram_addr[9:0]] : 16'h0000;

   always @(posedge clk) begin
      if (rst) sram[10'h040] <= 16'hBEEF;
      else if (!ce_n && !we_n) sram[ram_addr[9:0]] <= ram_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        rw;
      logic        mtr;
      logic [3:0]  rd;
      logic [15:0] alu;
      logic        exp_rw;
      logic        exp_mtr;
      logic [3:0]  exp_rd;
      logic [15:0] exp_alu;
   } vec_t;

   vec_t vecs [4];
   logic [7:0] stall_seq, oel_seq, wel_seq, rw_seq;

   initial begin
      vecs[0] = '{1'b1, 1'b0, 4'h3, 16'h1234, 1'b1, 1'b0, 4'h3, 16'h1234};
      vecs[1] = '{1'b0, 1'b1, 4'hF, 16'hFFFF, 1'b0, 1'b1, 4'hF, 16'hFFFF};
      vecs[2] = '{1'b1, 1'b1, 4'h0, 16'h0000, 1'b1, 1'b1, 4'h0, 16'h0000};
      vecs[3] = '{1'b1, 1'b0, 4'hA, 16'h8001, 1'b1, 1'b0, 4'hA, 16'h8001};

      rst = 1'b1; memread = 1'b1; memwrite = 1'b0; addr = 16'h0040; wdata = 16'h0;
      memtoreg = 1'b0; regdst = 4'h0; regwrite = 1'b0; alures = 16'h0;

      // Reset held two cycles with a pending load
      for (int k = 0; k < 2; k++) begin
         next_cycle();
         @(negedge clk);
         chk("rst_ce_n", ce_n, 1'b1);
         chk("rst_oe_n", oe_n, 1'b1);
         chk("rst_we_n", we_n, 1'b1);
         chk("rst_stall", stall, 1'b0);
         chk("rst_memres", memres, 16'h0);
      end
      next_cycle();
      rst = 1'b0; memread = 1'b0;

      // Pass-through vectors with no memory op
      foreach (vecs[i]) begin
         regwrite = vecs[i].rw; memtoreg = vecs[i].mtr; regdst = vecs[i].rd; alures = vecs[i].alu;
         @(negedge clk);
         chk("pt_regwrite", regwrite_o, vecs[i].exp_rw);
         chk("pt_memtoreg", memtoreg_o, vecs[i].exp_mtr);
         chk("pt_regdst", regdst_o, vecs[i].exp_rd);
         chk("pt_alures", alures_o, vecs[i].exp_alu);
         chk("pt_stall", stall, 1'b0);
         next_cycle();
      end

      // Load from 0x0040
      stall_seq = '0; oel_seq = '0; rw_seq = '0;
      for (int k = 0; k < 4; k++) begin
         memread = 1'b1; addr = 16'h0040; regwrite = 1'b1; memtoreg = 1'b1;
         @(negedge clk);
         stall_seq[k] = stall; oel_seq[k] = ~oe_n; rw_seq[k] = regwrite_o;
         if (k == 1) chk("ld_addr", ram_addr, 18'h00040);
         if (k == 3) chk("ld_memres", memres, 16'hBEEF);
         next_cycle();
      end
      memread = 1'b0; regwrite = 1'b0;
      chk("ld_stall_seq", stall_seq, 8'b0000_0111);
      chk("ld_oe_seq", oel_seq, 8'b0000_0110);
      chk("ld_rw_seq", rw_seq, 8'b0000_1000);

      // Store 0xA5A5 to 0x0100 followed at once by a load of 0x0100
      stall_seq = '0; oel_seq = '0; wel_seq = '0;
      for (int k = 0; k < 8; k++) begin
         memwrite = (k < 4); memread = (k >= 4);
         addr = 16'h0100; wdata = (k < 4) ? 16'hA5A5 : 16'h0000;
         @(negedge clk);
         stall_seq[k] = stall; oel_seq[k] = ~oe_n; wel_seq[k] = ~we_n;
         if (k == 1) chk("st_wdata", ram_wdata, 16'hA5A5);
         if (k == 7) chk("stld_memres", memres, 16'hA5A5);
         next_cycle();
      end
      memwrite = 1'b0; memread = 1'b0;
      chk("stld_stall_seq", stall_seq, 8'b0111_0111);
      chk("stld_we_seq", wel_seq, 8'b0000_0110);
      chk("stld_oe_seq", oel_seq, 8'b0110_0000);

      // Read and write both requested: store wins
      oel_seq = '0; wel_seq = '0;
      for (int k = 0; k < 4; k++) begin
         memread = 1'b1; memwrite = 1'b1; addr = 16'h0200; wdata = 16'h1111;
         @(negedge clk);
         oel_seq[k] = ~oe_n; wel_seq[k] = ~we_n;
         if (k == 3) chk("both_memres", memres, 16'hA5A5);
         next_cycle();
      end
      memread = 1'b0; memwrite = 1'b0;
      chk("both_we_seq", wel_seq, 8'b0000_0110);
      chk("both_oe_seq", oel_seq, 8'b0000_0000);

      // Reset during the second ACCESS cycle of a store
      stall_seq = '0; wel_seq = '0;
      for (int k = 0; k < 5; k++) begin
         memwrite = (k < 3); rst = (k == 2); addr = 16'h0300; wdata = 16'h2222;
         @(negedge clk);
         stall_seq[k] = stall; wel_seq[k] = ~we_n;
         if (k == 3) begin
            chk("abort_ce_n", ce_n, 1'b1);
            chk("abort_memres", memres, 16'h0);
         end
         next_cycle();
      end
      memwrite = 1'b0; rst = 1'b0;
      chk("abort_we_seq", wel_seq, 8'b0000_0110);
      chk("abort_stall_seq", stall_seq, 8'b0000_0011);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
